// File: rtl/cntdn_pkg.sv
// Shared definitions for the cntdn down-counter: state encoding and default widths.
package cntdn_pkg;

  localparam int CNTDN_CW_DEF = 128;
  localparam int CNTDN_DW_DEF = 1;

  // Code 2'd3 is unused and treated as illegal by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2
  } state_t;

endpackage

// File: rtl/cntdn_if.sv
// Control/status bundle of the cntdn down-counter; master drives controls, slave is the counter.
interface cntdn_if #(
  parameter int CW = 128,
  parameter int DW = 1
);

  logic          ce_i;
  logic          load_i;
  logic [CW-1:0] load_val_i;
  logic [DW-1:0] dec_i;
  logic          start_i;
  logic          stop_i;
  logic [CW-1:0] cnt_o;
  logic          busy_o;
  logic          zero_o;
  logic          done_o;

  modport master (
    output ce_i, load_i, load_val_i, dec_i, start_i, stop_i,
    input  cnt_o, busy_o, zero_o, done_o
  );

  modport slave (
    input  ce_i, load_i, load_val_i, dec_i, start_i, stop_i,
    output cnt_o, busy_o, zero_o, done_o
  );

endinterface

// File: rtl/cntdn_satsub.sv
// Combinational CW-bit saturating subtractor: diff = a - b, clamped to zero (sat=1) when b >= a.
module cntdn_satsub #(
  parameter int CW = 128,
  parameter int DW = 1
) (
  input  logic [CW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [CW-1:0] diff,
  output logic          sat
);

  logic [CW-1:0] b_ext;

  assign b_ext = CW'(b);
  assign sat   = (b_ext >= a);
  assign diff  = sat ? '0 : (a - b_ext);

endmodule

// File: rtl/cntdn.sv
// Loadable saturating down-counter/timer with one-cycle done pulse.
// Optional periodic reload when CNTDN_AUTO_RELOAD_EN is defined.
module cntdn
  import cntdn_pkg::*;
#(
  parameter int CW = CNTDN_CW_DEF,
  parameter int DW = CNTDN_DW_DEF
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  cntdn_if.slave bus
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] diff;
  logic          sat;

`ifdef CNTDN_AUTO_RELOAD_EN
  logic [CW-1:0] reload_q;
`endif

  cntdn_satsub #(.CW(CW), .DW(DW)) u_satsub (
    .a    (cnt),
    .b    (bus.dec_i),
    .diff (diff),
    .sat  (sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
`ifdef CNTDN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else if (bus.load_i) begin
      state <= ST_IDLE;
      cnt   <= bus.load_val_i;
`ifdef CNTDN_AUTO_RELOAD_EN
      reload_q <= bus.load_val_i;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.stop_i && bus.start_i)
            state <= (cnt == '0) ? ST_EXPIRE : ST_RUN;
        end
        ST_RUN: begin
          if (bus.stop_i) begin
            state <= ST_IDLE;
          end else if (bus.ce_i) begin
            if (sat) begin
              cnt   <= '0;
              state <= ST_EXPIRE;
            end else begin
              cnt <= diff;
            end
          end
        end
        ST_EXPIRE: begin
`ifdef CNTDN_AUTO_RELOAD_EN
          // Periodic mode: restart from the reload value unless aborted or empty.
          if (bus.stop_i || (reload_q == '0)) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= reload_q;
            state <= ST_RUN;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cnt_o  = cnt;
  assign bus.busy_o = (state == ST_RUN);
  assign bus.zero_o = (cnt == '0);
  assign bus.done_o = (state == ST_EXPIRE);

endmodule

// File: tb/tb_cntdn.sv
// Directed self-checking bench for cntdn (CW=8, DW=2); expectations follow CNTDN_AUTO_RELOAD_EN.
module tb_cntdn;

  localparam int CW = 8;
  localparam int DW = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cntdn_if #(.CW(CW), .DW(DW)) bus ();

  cntdn #(.CW(CW), .DW(DW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one edge; inputs set afterwards are stable before the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [CW-1:0] val);
    bus.load_i     = 1'b1;
    bus.load_val_i = val;
    tick();
    bus.load_i     = 1'b0;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  logic [CW-1:0] exp_cnt  [8];
  logic          exp_done [8];

  initial begin
    bus.ce_i       = 1'b0;
    bus.load_i     = 1'b0;
    bus.load_val_i = '0;
    bus.dec_i      = '0;
    bus.start_i    = 1'b0;
    bus.stop_i     = 1'b0;

    // Reset values
    #12;
    check("rst_cnt",  32'(bus.cnt_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_zero", 32'(bus.zero_o), 1);
    check("rst_done", 32'(bus.done_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic countdown: load 4, dec 1
    do_load(8'd4);
    check("basic_load_cnt",  32'(bus.cnt_o), 4);
    check("basic_load_busy", 32'(bus.busy_o), 0);
    do_start();
    bus.ce_i  = 1'b1;
    bus.dec_i = 2'd1;
    check("basic_run_cnt",  32'(bus.cnt_o), 4);
    check("basic_run_busy", 32'(bus.busy_o), 1);
    for (int i = 3; i >= 1; i--) begin
      tick();
      check("basic_dec_cnt",  32'(bus.cnt_o), 32'(i));
      check("basic_dec_done", 32'(bus.done_o), 0);
    end
    tick();
    check("basic_exp_cnt",  32'(bus.cnt_o), 0);
    check("basic_exp_done", 32'(bus.done_o), 1);
    check("basic_exp_busy", 32'(bus.busy_o), 0);
    check("basic_exp_zero", 32'(bus.zero_o), 1);
    tick();
    check("basic_post_done", 32'(bus.done_o), 0);
`ifdef CNTDN_AUTO_RELOAD_EN
    check("basic_post_cnt",  32'(bus.cnt_o), 4);
    check("basic_post_busy", 32'(bus.busy_o), 1);
`else
    check("basic_post_cnt",  32'(bus.cnt_o), 0);
    check("basic_post_busy", 32'(bus.busy_o), 0);
`endif
    bus.ce_i = 1'b0;
    do_load(8'd0);

    // Saturation: load 5, dec 3 -> 5,2,0 (never wraps)
    do_load(8'd5);
    do_start();
    check("sat_cnt0", 32'(bus.cnt_o), 5);
    bus.ce_i  = 1'b1;
    bus.dec_i = 2'd3;
    tick();
    check("sat_cnt1", 32'(bus.cnt_o), 2);
    check("sat_done1", 32'(bus.done_o), 0);
    tick();
    check("sat_cnt2", 32'(bus.cnt_o), 0);
    check("sat_done2", 32'(bus.done_o), 1);
    tick();
    check("sat_done3", 32'(bus.done_o), 0);
`ifdef CNTDN_AUTO_RELOAD_EN
    check("sat_cnt3", 32'(bus.cnt_o), 5);
`else
    check("sat_cnt3", 32'(bus.cnt_o), 0);
`endif
    bus.ce_i = 1'b0;
    do_load(8'd0);

    // Priority: load beats stop/start/ce in RUN
    do_load(8'd7);
    do_start();
    check("pri_run_busy", 32'(bus.busy_o), 1);
    check("pri_run_cnt",  32'(bus.cnt_o), 7);
    bus.load_i     = 1'b1;
    bus.load_val_i = 8'd9;
    bus.stop_i     = 1'b1;
    bus.start_i    = 1'b1;
    bus.ce_i       = 1'b1;
    bus.dec_i      = 2'd1;
    tick();
    bus.load_i  = 1'b0;
    bus.stop_i  = 1'b0;
    bus.start_i = 1'b0;
    bus.ce_i    = 1'b0;
    check("pri_load_cnt",  32'(bus.cnt_o), 9);
    check("pri_load_busy", 32'(bus.busy_o), 0);
    check("pri_load_done", 32'(bus.done_o), 0);
    do_start();
    check("pri_restart_busy", 32'(bus.busy_o), 1);
    bus.stop_i = 1'b1;
    bus.ce_i   = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    bus.ce_i   = 1'b0;
    check("stop_hold_cnt",  32'(bus.cnt_o), 9);
    check("stop_hold_busy", 32'(bus.busy_o), 0);
    do_start();
    check("resume_cnt",  32'(bus.cnt_o), 9);
    check("resume_busy", 32'(bus.busy_o), 1);
    bus.ce_i = 1'b1;
    tick();
    check("resume_dec_cnt", 32'(bus.cnt_o), 8);

    // dec_i == 0 holds the count
    bus.dec_i = 2'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("dec0_cnt", 32'(bus.cnt_o), 8);
    end
    check("dec0_busy", 32'(bus.busy_o), 1);
    bus.ce_i = 1'b0;

    // start during RUN is ignored
    do_start();
    check("run_start_cnt",  32'(bus.cnt_o), 8);
    check("run_start_busy", 32'(bus.busy_o), 1);
    check("run_start_done", 32'(bus.done_o), 0);

    // start with cnt == 0 -> immediate expiry, no RUN cycle
    do_load(8'd0);
    do_start();
    check("zstart_done", 32'(bus.done_o), 1);
    check("zstart_busy", 32'(bus.busy_o), 0);
    tick();
    check("zstart_post_done", 32'(bus.done_o), 0);
    check("zstart_post_busy", 32'(bus.busy_o), 0);

    // Periodic behaviour: load 3, dec 1
`ifdef CNTDN_AUTO_RELOAD_EN
    exp_cnt  = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_cnt  = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_load(8'd3);
    do_start();
    check("per_cnt_start", 32'(bus.cnt_o), 3);
    bus.ce_i  = 1'b1;
    bus.dec_i = 2'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("per_cnt",  32'(bus.cnt_o), 32'(exp_cnt[i]));
      check("per_done", 32'(bus.done_o), 32'(exp_done[i]));
    end
    // Periodic mode sits in EXPIRE here; stop suppresses the reload.
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    bus.ce_i   = 1'b0;
    check("exp_stop_cnt",  32'(bus.cnt_o), 0);
    check("exp_stop_busy", 32'(bus.busy_o), 0);
    check("exp_stop_done", 32'(bus.done_o), 0);
    tick();
    check("exp_stop_idle", 32'(bus.busy_o), 0);

    // Asynchronous reset mid-RUN with cnt=5
    do_load(8'd5);
    do_start();
    check("mid_busy", 32'(bus.busy_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_cnt",  32'(bus.cnt_o), 0);
    check("arst_busy", 32'(bus.busy_o), 0);
    check("arst_zero", 32'(bus.zero_o), 1);
    check("arst_done", 32'(bus.done_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("arst_post_done", 32'(bus.done_o), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
